// File: rtl/divider_serial_p.sv
// Serial-in/serial-out restoring divider: nibble-loaded operands, one quotient bit per cycle, bit-serial result.
// Latency: first result bit DATA_W+2 cycles after the last nibble; no backpressure, input ignored while computing/streaming.
module divider_serial_p #(
   parameter int DATA_W = 8,
   parameter int NIB_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [NIB_W-1:0] in_data,
   input  logic             in_signed,
   output logic             busy,
   output logic             out_valid,
   output logic             out_data,
   output logic             out_err
);
   localparam int FRM_W = 2*DATA_W;
   localparam int N_NIB = FRM_W/NIB_W;
   localparam int CNT_W = $clog2(FRM_W);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_NIB  = CNT_W'(N_NIB-1);
   localparam logic [CNT_W-1:0] LAST_CALC = CNT_W'(DATA_W-1);
   localparam logic [CNT_W-1:0] LAST_OUT  = CNT_W'(FRM_W-1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_FIX, S_OUT} state_t;

   state_t                   r_state, w_next;
   logic [FRM_W-NIB_W-1:0]   r_shift;
   logic                     r_sgn;
   logic [CNT_W-1:0]         r_cnt;
   logic [DATA_W-1:0]        r_dvd_raw;
   logic                     r_dvd_neg, r_dvs_neg;
   logic [DATA_W-1:0]        r_dvs;
   logic [DATA_W-1:0]        r_quo;
   logic [DATA_W:0]          r_rem;
   logic [FRM_W-1:0]         r_out;
   logic                     r_err;

   logic [FRM_W-1:0]         w_frame;
   logic [DATA_W-1:0]        w_dvd, w_dvs, w_dvd_mag, w_dvs_mag;
   logic                     w_dvd_neg, w_dvs_neg;
   logic [DATA_W+1:0]        w_rem_sh, w_diff;
   logic                     w_ge;
   logic [DATA_W-1:0]        w_q_fix, w_r_fix;

   assign w_frame   = {r_shift, in_data};
   assign w_dvd     = w_frame[FRM_W-1:DATA_W];
   assign w_dvs     = w_frame[DATA_W-1:0];
   assign w_dvd_neg = r_sgn & w_dvd[DATA_W-1];
   assign w_dvs_neg = r_sgn & w_dvs[DATA_W-1];
   assign w_dvd_mag = w_dvd_neg ? -w_dvd : w_dvd;
   assign w_dvs_mag = w_dvs_neg ? -w_dvs : w_dvs;

   // Trial subtraction one bit wider than the remainder so the borrow decides the quotient bit.
   assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
   assign w_diff   = w_rem_sh - {2'b00, r_dvs};
   assign w_ge     = ~w_diff[DATA_W+1];

   // Most-negative / -1 needs no special case: the magnitude 2^(DATA_W-1) with equal signs is the wanted pattern.
   always_comb begin
      w_q_fix = r_quo;
      w_r_fix = r_rem[DATA_W-1:0];
      if (r_dvs == '0) begin
         w_q_fix = '1;
         w_r_fix = r_dvd_raw;
      end else begin
         if (r_dvd_neg ^ r_dvs_neg) w_q_fix = -r_quo;
         if (r_dvd_neg)             w_r_fix = -r_rem[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      busy      = 1'b0;
      out_valid = 1'b0;
      out_data  = 1'b0;
      out_err   = 1'b0;
      case (r_state)
         S_IDLE: if (in_valid) w_next = S_LOAD;
         S_LOAD: begin
            busy = 1'b1;
            if (!in_valid)               w_next = S_IDLE;
            else if (r_cnt == LAST_NIB)  w_next = S_CALC;
         end
         S_CALC: begin
            busy = 1'b1;
            if (r_cnt == LAST_CALC) w_next = S_FIX;
         end
         S_FIX: begin
            busy   = 1'b1;
            w_next = S_OUT;
         end
         S_OUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = r_out[FRM_W-1];
            out_err   = r_err;
            if (r_cnt == LAST_OUT) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift   <= '0;
         r_sgn     <= 1'b0;
         r_cnt     <= '0;
         r_dvd_raw <= '0;
         r_dvd_neg <= 1'b0;
         r_dvs_neg <= 1'b0;
         r_dvs     <= '0;
         r_quo     <= '0;
         r_rem     <= '0;
         r_out     <= '0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_shift <= w_frame[FRM_W-NIB_W-1:0];
               r_sgn   <= in_signed;
               r_cnt   <= ONE;
            end
            S_LOAD: if (in_valid) begin
               r_shift <= w_frame[FRM_W-NIB_W-1:0];
               r_cnt   <= r_cnt + ONE;
               if (r_cnt == LAST_NIB) begin
                  r_cnt     <= '0;
                  r_dvd_raw <= w_dvd;
                  r_dvd_neg <= w_dvd_neg;
                  r_dvs_neg <= w_dvs_neg;
                  r_dvs     <= w_dvs_mag;
                  r_quo     <= w_dvd_mag;
                  r_rem     <= '0;
               end
            end
            S_CALC: begin
               r_quo <= {r_quo[DATA_W-2:0], w_ge};
               r_rem <= w_ge ? w_diff[DATA_W:0] : w_rem_sh[DATA_W:0];
               r_cnt <= r_cnt + ONE;
            end
            S_FIX: begin
               r_out <= {w_q_fix, w_r_fix};
               r_err <= (r_dvs == '0);
               r_cnt <= '0;
            end
            S_OUT: begin
               r_out <= {r_out[FRM_W-2:0], 1'b0};
               r_cnt <= r_cnt + ONE;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_divider_serial_p.sv
// Scoreboard bench for divider_serial_p: stimulus pushes model results, a monitor collects serial frames and compares.
module tb_divider_serial_p;
   localparam int DW = 8;
   localparam int NW = 4;

   logic          clk, rst, in_valid, in_signed;
   logic [NW-1:0] in_data;
   logic          busy, out_valid, out_data, out_err;

   typedef struct {
      logic [DW-1:0] q;
      logic [DW-1:0] r;
      logic          err;
      int            c_last;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   divider_serial_p #(.DATA_W(DW), .NIB_W(NW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_signed(in_signed),
      .busy(busy), .out_valid(out_valid), .out_data(out_data), .out_err(out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: plain integer division with the documented special cases.
   function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
      exp_t e;
      int   sa, sb;
      e.c_last = 0;
      e.err    = 1'b0;
      if (b == 0) begin
         e.q = '1; e.r = a; e.err = 1'b1;
      end else if (s) begin
         sa = $signed(a);
         sb = $signed(b);
         if (sa == -(1 << (DW-1)) && sb == -1) begin
            e.q = a; e.r = '0;
         end else begin
            e.q = DW'(sa / sb);
            e.r = DW'(sa % sb);
         end
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   task automatic send_frame(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
      logic [2*DW-1:0] w;
      exp_t            e;
      w = {a, b};
      e = model(a, b, s);
      for (int i = 0; i < 2*DW/NW; i++) begin
         in_valid  = 1'b1;
         in_data   = w[2*DW-1-NW*i -: NW];
         in_signed = (i == 0) ? s : ~s;
         if (i == 2*DW/NW-1) begin
            e.c_last = cyc;
            exp_q.push_back(e);
         end
         @(posedge clk); #1;
      end
   endtask

   // Called at c+1: keeps in_valid high with junk up to the last output bit.
   task automatic hold_junk();
      for (int i = 0; i < 3*DW+1; i++) begin
         in_valid  = 1'b1;
         in_data   = NW'($urandom);
         in_signed = 1'($urandom);
         @(posedge clk); #1;
      end
   endtask

   // Called at c+1: checks busy on both sides of the frame's final boundary.
   task automatic finish_idle();
      in_valid = 1'b0;
      repeat (3*DW) @(posedge clk);
      #1;
      check("busy_last_bit", busy, 1'b1);
      check("valid_last_bit", out_valid, 1'b1);
      @(posedge clk); #1;
      check("busy_first_idle", busy, 1'b0);
      check("valid_first_idle", out_valid, 1'b0);
   endtask

   // Monitor: assembles each output frame and pops the scoreboard.
   initial begin : monitor
      logic [2*DW-1:0] sh;
      int              nbits, first_cyc;
      logic            err0, err_ok;
      exp_t            e;
      nbits = 0; sh = '0; first_cyc = 0; err0 = 1'b0; err_ok = 1'b1;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            nbits = 0;
         end else if (out_valid === 1'b1) begin
            if (nbits == 0) begin
               first_cyc = cyc; err0 = out_err; err_ok = 1'b1;
            end else if (out_err !== err0) begin
               err_ok = 1'b0;
            end
            sh = {sh[2*DW-2:0], out_data};
            nbits++;
            if (nbits == 2*DW) begin
               nbits = 0;
               if (exp_q.size() == 0) begin
                  check("unexpected_output_frame", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("quotient", sh[2*DW-1:DW], e.q);
                  check("remainder", sh[DW-1:0], e.r);
                  check("err_flag", {err_ok, err0}, {1'b1, e.err});
                  check("first_bit_latency", first_cyc - e.c_last, DW + 2);
               end
            end
         end else if (nbits != 0) begin
            check("truncated_output_frame", nbits, 2*DW);
            nbits = 0;
         end else if (out_data !== 1'b0 || out_err !== 1'b0) begin
            check("idle_out_data_err", {out_data, out_err}, 2'b00);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

   initial begin : stim
      logic          bad_valid;
      logic [DW-1:0] a, b;
      logic          s, junk;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_signed = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 1'b0);
      check("rst_out_err", out_err, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      send_frame(8'hC8, 8'h07, 1'b0); finish_idle();
      send_frame(8'h9C, 8'h07, 1'b1); finish_idle();
      send_frame(8'h55, 8'h00, 1'b0); finish_idle();
      send_frame(8'h85, 8'h00, 1'b1); finish_idle();
      send_frame(8'h80, 8'hFF, 1'b1); finish_idle();

      // Abort after two nibbles.
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = NW'(i + 3); in_signed = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("abort_busy_before", busy, 1'b1);
      @(posedge clk); #1;
      check("abort_busy_after", busy, 1'b0);
      bad_valid = 1'b0;
      repeat (3*DW) begin
         if (out_valid !== 1'b0) bad_valid = 1'b1;
         @(posedge clk); #1;
      end
      check("abort_no_output", bad_valid, 1'b0);

      // Junk held through CALC/OUT, then a frame starting in the first IDLE cycle.
      send_frame(8'h09, 8'h03, 1'b0); hold_junk();
      send_frame(8'hF0, 8'h0B, 1'b1); hold_junk();
      send_frame(8'h64, 8'h0A, 1'b0); finish_idle();

      for (int n = 0; n < 25; n++) begin
         a    = DW'($urandom);
         b    = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
         s    = 1'($urandom);
         junk = 1'($urandom);
         if ($urandom_range(0, 9) == 0) begin a = 8'h80; b = 8'hFF; s = 1'b1; end
         send_frame(a, b, s);
         if (junk) hold_junk();
         else      finish_idle();
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset during output bit 5 discards the frame.
      send_frame(8'hA7, 8'h05, 1'b0);
      in_valid = 1'b0;
      repeat (DW + 6) @(posedge clk);
      #1;
      check("pre_rst_out_valid", out_valid, 1'b1);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_out_err", out_err, 1'b0);
      check("midrst_out_data", out_data, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      send_frame(8'h0F, 8'h04, 1'b0); finish_idle();

      repeat (4*DW) @(posedge clk);
      #1;
      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
